// File: rtl/write_back_stage.sv
// Write-back stage: selects ALU / load / PC+4 data, waits for load responses,
// and drives the register-file write port one cycle after the data is known.
package write_back_pkg;
    typedef enum logic [1:0] {
        WRITE_BACK_SEL_ALU = 2'd0,
        WRITE_BACK_SEL_MEM = 2'd1,
        WRITE_BACK_SEL_PC  = 2'd2
    } write_back_select_t;
endpackage

module write_back_stage
    import write_back_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_write_enable,
    input  logic [REG_ADDR_W-1:0] in_addr_rd,
    input  write_back_select_t    in_sel,
    input  logic [XLEN-1:0]       in_alu_result,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [2:0]            in_funct3,
    input  logic                  mem_rdata_valid,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic                  rf_write_enable,
    output logic [REG_ADDR_W-1:0] rf_addr_rd,
    output logic [XLEN-1:0]       rf_write_data,
    output logic                  wb_busy,
    output logic [REG_ADDR_W-1:0] wb_pending_rd
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        COMMIT   = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_t                  state, state_next;
    logic                    accept;
    logic                    is_load;
    logic [XLEN-1:0]         direct_data;

    // Captured load context, live only while in WAIT_MEM
    logic                    ld_we_p0;
    logic [REG_ADDR_W-1:0]   ld_rd_p0;
    logic [2:0]              ld_funct3_p0;
    logic [1:0]              ld_off_p0;

    logic                    commit_we_p1;
    logic [REG_ADDR_W-1:0]   commit_rd_p1;
    logic [XLEN-1:0]         commit_data_p1;

    function automatic logic [XLEN-1:0] load_extend(
        input logic [XLEN-1:0] word,
        input logic [2:0]      funct3,
        input logic [1:0]      off
    );
        logic signed [7:0]  byte_v;
        logic signed [15:0] half_v;
        byte_v = word[8*off +: 8];
        half_v = off[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  return {{(XLEN-8){byte_v[7]}}, byte_v};
            3'b100:  return {{(XLEN-8){1'b0}}, byte_v};
            3'b001:  return {{(XLEN-16){half_v[15]}}, half_v};
            3'b101:  return {{(XLEN-16){1'b0}}, half_v};
            default: return word;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, COMMIT: begin
                if (accept) state_next = is_load ? WAIT_MEM : COMMIT;
                else        state_next = IDLE;
            end
            WAIT_MEM: begin
                if (mem_rdata_valid) state_next = COMMIT;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready        = (state != WAIT_MEM);
        wb_busy         = (state == WAIT_MEM);
        wb_pending_rd   = (state == WAIT_MEM) ? ld_rd_p0 : '0;
        rf_write_enable = commit_we_p1;
        rf_addr_rd      = commit_rd_p1;
        rf_write_data   = commit_data_p1;
    end

    assign accept  = in_valid && in_ready;
    assign is_load = (in_sel == WRITE_BACK_SEL_MEM);
    // Unused select encodings fall through to the ALU result
    assign direct_data = (in_sel == WRITE_BACK_SEL_PC) ? in_pc + PC_STEP : in_alu_result;

    // Stage p0: load capture on accept
    always_ff @(posedge clk) begin
        if (!reset) begin
            ld_we_p0     <= 1'b0;
            ld_rd_p0     <= '0;
            ld_funct3_p0 <= '0;
            ld_off_p0    <= '0;
        end else if (accept && is_load) begin
            ld_we_p0     <= in_write_enable;
            ld_rd_p0     <= in_addr_rd;
            ld_funct3_p0 <= in_funct3;
            ld_off_p0    <= in_alu_result[1:0];
        end
    end

    // Stage p1: commit registers; address/data hold outside COMMIT
    always_ff @(posedge clk) begin
        if (!reset) begin
            commit_we_p1   <= 1'b0;
            commit_rd_p1   <= '0;
            commit_data_p1 <= '0;
        end else if (accept && !is_load) begin
            commit_we_p1   <= in_write_enable && (in_addr_rd != '0);
            commit_rd_p1   <= in_addr_rd;
            commit_data_p1 <= direct_data;
        end else if (state == WAIT_MEM && mem_rdata_valid) begin
            commit_we_p1   <= ld_we_p0 && (ld_rd_p0 != '0);
            commit_rd_p1   <= ld_rd_p0;
            commit_data_p1 <= load_extend(mem_rdata, ld_funct3_p0, ld_off_p0);
        end else begin
            commit_we_p1   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_write_back_stage.sv
// Directed bench for write_back_stage: ALU/PC/load paths, x0 suppression,
// back-to-back commits, reset during a pending load and stray responses.
module tb_write_back_stage;
    import write_back_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic               in_write_enable;
    logic [4:0]         in_addr_rd;
    write_back_select_t in_sel;
    logic [31:0]        in_alu_result;
    logic [31:0]        in_pc;
    logic [2:0]         in_funct3;
    logic               mem_rdata_valid;
    logic [31:0]        mem_rdata;
    logic               rf_write_enable;
    logic [4:0]         rf_addr_rd;
    logic [31:0]        rf_write_data;
    logic               wb_busy;
    logic [4:0]         wb_pending_rd;

    int vectors = 0;
    int miscompares = 0;

    write_back_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_write_enable(in_write_enable), .in_addr_rd(in_addr_rd),
        .in_sel(in_sel), .in_alu_result(in_alu_result), .in_pc(in_pc),
        .in_funct3(in_funct3),
        .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
        .rf_write_enable(rf_write_enable), .rf_addr_rd(rf_addr_rd),
        .rf_write_data(rf_write_data),
        .wb_busy(wb_busy), .wb_pending_rd(wb_pending_rd)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input write_back_select_t sel, input logic we, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] pc, input logic [2:0] f3);
        in_valid        = 1'b1;
        in_sel          = sel;
        in_write_enable = we;
        in_addr_rd      = rd;
        in_alu_result   = alu;
        in_pc           = pc;
        in_funct3       = f3;
    endtask

    task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] word, input logic [31:0] exp);
        drive(WRITE_BACK_SEL_MEM, 1'b1, rd, addr, 32'h0, f3);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check_eq({tag, "_ready"}, 32'(in_ready), 32'd0);
            check_eq({tag, "_busy"}, 32'(wb_busy), 32'd1);
            check_eq({tag, "_prd"}, 32'(wb_pending_rd), 32'(rd));
            check_eq({tag, "_nowe"}, 32'(rf_write_enable), 32'd0);
            step();
        end
        mem_rdata_valid = 1'b1;
        mem_rdata       = word;
        step();
        mem_rdata_valid = 1'b0;
        check_eq({tag, "_we"}, 32'(rf_write_enable), 32'd1);
        check_eq({tag, "_rd"}, 32'(rf_addr_rd), 32'(rd));
        check_eq({tag, "_data"}, rf_write_data, exp);
        check_eq({tag, "_busy_off"}, 32'(wb_busy), 32'd0);
        step();
        check_eq({tag, "_we_off"}, 32'(rf_write_enable), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        in_valid = 1'b0;
        in_sel = WRITE_BACK_SEL_ALU;
        in_write_enable = 1'b0;
        in_addr_rd = '0;
        in_alu_result = '0;
        in_pc = '0;
        in_funct3 = '0;
        mem_rdata_valid = 1'b0;
        mem_rdata = '0;
        step();
        step();
        check_eq("rst_we", 32'(rf_write_enable), 32'd0);
        check_eq("rst_rd", 32'(rf_addr_rd), 32'd0);
        check_eq("rst_data", rf_write_data, 32'd0);
        check_eq("rst_busy", 32'(wb_busy), 32'd0);
        check_eq("rst_prd", 32'(wb_pending_rd), 32'd0);
        check_eq("rst_ready", 32'(in_ready), 32'd1);
        reset = 1'b1;
        step();

        // ALU path
        drive(WRITE_BACK_SEL_ALU, 1'b1, 5'd5, 32'h12345678, 32'h0, 3'd0);
        step();
        in_valid = 1'b0;
        check_eq("alu_we", 32'(rf_write_enable), 32'd1);
        check_eq("alu_rd", 32'(rf_addr_rd), 32'd5);
        check_eq("alu_data", rf_write_data, 32'h12345678);
        step();
        check_eq("alu_we_off", 32'(rf_write_enable), 32'd0);
        check_eq("alu_hold", rf_write_data, 32'h12345678);

        // PC+4 with wrap, then back-to-back
        drive(WRITE_BACK_SEL_PC, 1'b1, 5'd1, 32'hAAAA5555, 32'hFFFFFFFC, 3'd0);
        step();
        check_eq("jal_wrap", rf_write_data, 32'h00000000);
        check_eq("jal_we", 32'(rf_write_enable), 32'd1);
        drive(WRITE_BACK_SEL_PC, 1'b1, 5'd1, 32'hAAAA5555, 32'h00000100, 3'd0);
        step();
        in_valid = 1'b0;
        check_eq("jal_data", rf_write_data, 32'h00000104);
        step();

        // Loads
        do_load("lb",  5'd7, 3'b000, 32'h1003, 32'h80FFFFFF, 32'hFFFFFF80);
        do_load("lbu", 5'd7, 3'b100, 32'h1003, 32'h80FFFFFF, 32'h00000080);
        do_load("lhu", 5'd7, 3'b101, 32'h1002, 32'h80FFFFFF, 32'h000080FF);
        do_load("lh",  5'd8, 3'b001, 32'h1003, 32'h80FFFFFF, 32'hFFFF80FF);
        do_load("lb0", 5'd9, 3'b000, 32'h1000, 32'h12345687, 32'hFFFFFF87);
        do_load("lbu1", 5'd9, 3'b100, 32'h1001, 32'h1234A687, 32'h000000A6);
        do_load("lh0", 5'd4, 3'b001, 32'h1000, 32'h00017FFF, 32'h00007FFF);
        do_load("lw",  5'd2, 3'b010, 32'h1000, 32'hDEADBEEF, 32'hDEADBEEF);
        do_load("f3x", 5'd2, 3'b011, 32'h1001, 32'hCAFEF00D, 32'hCAFEF00D);

        // x0 and store suppression
        drive(WRITE_BACK_SEL_ALU, 1'b1, 5'd0, 32'h0000DEAD, 32'h0, 3'd0);
        step();
        check_eq("x0_we", 32'(rf_write_enable), 32'd0);
        drive(WRITE_BACK_SEL_ALU, 1'b0, 5'd3, 32'h0000BEEF, 32'h0, 3'd0);
        step();
        in_valid = 1'b0;
        check_eq("st_we", 32'(rf_write_enable), 32'd0);
        check_eq("st_rd", 32'(rf_addr_rd), 32'd3);
        check_eq("st_ready", 32'(in_ready), 32'd1);
        step();

        // Back-to-back ALU commits
        for (int i = 0; i < 4; i++) begin
            drive(WRITE_BACK_SEL_ALU, 1'b1, 5'(10 + i), 32'h1000 + 32'(i), 32'h0, 3'd0);
            check_eq("b2b_ready", 32'(in_ready), 32'd1);
            step();
            check_eq("b2b_we", 32'(rf_write_enable), 32'd1);
            check_eq("b2b_rd", 32'(rf_addr_rd), 32'(10 + i));
            check_eq("b2b_data", rf_write_data, 32'h1000 + 32'(i));
        end
        in_valid = 1'b0;
        step();
        check_eq("b2b_end", 32'(rf_write_enable), 32'd0);

        // Undefined select encoding behaves as ALU
        drive(write_back_select_t'(2'd3), 1'b1, 5'd6, 32'h0000CAFE, 32'h00000200, 3'd0);
        step();
        in_valid = 1'b0;
        check_eq("sel3_data", rf_write_data, 32'h0000CAFE);
        check_eq("sel3_we", 32'(rf_write_enable), 32'd1);
        step();

        // Reset while a load is pending
        drive(WRITE_BACK_SEL_MEM, 1'b1, 5'd9, 32'h2000, 32'h0, 3'b010);
        step();
        in_valid = 1'b0;
        check_eq("rml_busy_pre", 32'(wb_busy), 32'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_eq("rml_busy", 32'(wb_busy), 32'd0);
        check_eq("rml_ready", 32'(in_ready), 32'd1);
        check_eq("rml_data", rf_write_data, 32'd0);
        mem_rdata_valid = 1'b1;
        mem_rdata = 32'h55AA55AA;
        step();
        mem_rdata_valid = 1'b0;
        check_eq("rml_nowe", 32'(rf_write_enable), 32'd0);
        step();
        check_eq("rml_nowe2", 32'(rf_write_enable), 32'd0);
        check_eq("rml_data2", rf_write_data, 32'd0);

        // Stray response while idle
        mem_rdata_valid = 1'b1;
        mem_rdata = 32'h11111111;
        step();
        mem_rdata_valid = 1'b0;
        check_eq("stray_we", 32'(rf_write_enable), 32'd0);
        check_eq("stray_ready", 32'(in_ready), 32'd1);
        check_eq("stray_busy", 32'(wb_busy), 32'd0);
        step();
        check_eq("stray_we2", 32'(rf_write_enable), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
